regbank_arbiter: RTL
====================

# regbank_arbiter

Sequencer and two-requester round-robin arbiter for the 35×16-bit register bank. Owns the bank's write port (select C / data C) and secondary read port (select B); read port A stays with the datapath. Each accepted request is one single-word read or write. The write select parks at a non-existent register whenever no write is in progress, because the bank writes whichever register select C addresses on every clock.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `ADDR_W`, 6, register address width
- `N_REGS`, 35, number of implemented registers (addresses 0..34)
- `PARK_SEL`, 6'h3F, idle write select; addresses no register

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pN_valid` in 1: request present, for N = 0, 1.
- `pN_we` in 1: 1 = write, 0 = read.
- `pN_addr` in ADDR_W: register address.
- `pN_wdata` in DATA_W: write data.
- `pN_ready` out 1: one-cycle accept pulse.
- `pN_rsp_valid` out 1: one-cycle response pulse.
- `pN_rsp_err` out 1: address ≥ N_REGS; qualified by `pN_rsp_valid`.
- `pN_rsp_rdata` out DATA_W: read data; qualified by `pN_rsp_valid`.
- `sel_b` out ADDR_W: to bank read select B.
- `sel_c` out ADDR_W: to bank write select C.
- `data_c` out DATA_W: to bank write data C.
- `data_b` in DATA_W: from bank read data B (combinational).
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE. One transaction per pass, 3 cycles.
- **IDLE**
  - If any `pN_valid` is high, pick the winner:
    - only one valid: that requester wins.
    - both valid: the requester not granted last time wins.
    - pointer after reset favours p0.
  - Assert the winner's `pN_ready` combinationally in the same cycle.
  - Latch we, addr, wdata and owner into the command register; update the RR pointer; go to EXEC.
- **EXEC**
  - Valid write (addr < N_REGS): `sel_c` = addr, `data_c` = wdata. The bank captures the data on the edge that ends EXEC.
  - Valid read: `sel_b` = addr. `data_b` is captured into the response register on the edge that ends EXEC.
  - Invalid address: no bank access. `sel_c` stays PARK_SEL, error flag is set, response data is 0.
  - Go to RESP.
- **RESP**
  - Pulse the owner's `pN_rsp_valid` with rdata and err. Write responses return rdata = 0.
  - Go to IDLE.
- Outside EXEC-with-valid-write, `sel_c` = PARK_SEL and `data_c` = 0. The parked select is registered, so it never glitches onto a real address.
- `sel_b` holds its last value outside EXEC. The datapath must not depend on it.
- A requester keeps valid/we/addr/wdata stable until it sees ready. Changes before ready are legal; the arbiter samples only in the ready cycle.
- A write followed by a read of the same address, from either requester, returns the new value: the write commits before the later EXEC.
- Address width rule: comparison is unsigned on all ADDR_W bits. Addresses 35..63 are errors.

## Timing
- Accept-to-response latency: 2 cycles (ready at cycle t, rsp_valid at t+2).
- Maximum throughput: 1 transaction per 3 cycles. `pN_ready` is never high outside IDLE.
- Both requesters valid continuously: grants alternate p0, p1, p0, … with no starvation.
- Reset values:
  - state = IDLE, RR pointer favours p0.
  - `sel_b` = 0, `sel_c` = PARK_SEL, `data_c` = 0.
  - All ready, rsp_valid and rsp_err = 0; all rsp_rdata = 0; `busy` = 0.
- Reset asserted mid-transaction:
  - All outputs take reset values immediately (asynchronously).
  - A write in EXEC is abandoned; the bank may or may not have captured it, depending on the edge.
  - No response is issued for the aborted transaction.

## Structure
- Shared package `regbank_pkg`:
  - constants N_REGS, DATA_W, ADDR_W, PARK_SEL.
  - state enum {IDLE, EXEC, RESP}.
  - command struct {we, addr, wdata, owner}.
- One sub-module, `rr_arb2`: a two-input round-robin picker holding the last-grant flop, with an `update` input. The FSM and datapath live in `regbank_arbiter`.

## Test plan
- After reset, no requests → `sel_c` = 6'h3F and `busy` = 0 for 20 cycles. The bank model shows no register changes.
- p0 writes addr 5 = 16'hBEEF, then reads addr 5 → ready at t, `sel_c` = 5 only in cycle t+1, rsp at t+2. Read returns 16'hBEEF with err = 0.
- p0 and p1 valid together, held for 6 transactions → grant order p0, p1, p0, p1, p0, p1. Each rsp_valid goes only to its owner.
- p1 reads addr 34 after p0 writes 16'h1234 there → p1 rdata = 16'h1234. p1 then reads addr 40 → err = 1, rdata = 0, no bank write.
- p1 write to addr 35 → err = 1, `sel_c` stays 6'h3F throughout.
- Reset pulsed during EXEC of a p0 write → outputs return to reset values within the reset cycle, no rsp_valid. The next request after reset is granted to p0 when both are valid.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank sequencer and its arbiter.
package regbank_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;
   localparam int N_REGS = 35;
   localparam logic [ADDR_W-1:0] PARK_SEL  = 6'h3F;
   localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd34;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              owner;
   } cmd_t;

   // Unsigned compare over all address bits; 35..63 are out of range.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a <= LAST_ADDR);
   endfunction

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-input round-robin picker; the flop remembers which side won last.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   logic last_p1;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_p1 ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset as if p1 won last, so p0 is favoured first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_p1 <= 1'b1;
      end else if (update && (grant != 2'b00)) begin
         last_p1 <= grant[1];
      end else begin
         last_p1 <= last_p1;
      end
   end

endmodule

// File: rtl/regbank_arbiter.sv
// Sequencer owning the bank write port and read port B for two requesters.
module regbank_arbiter
   import regbank_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_valid,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ready,
   output logic              p0_rsp_valid,
   output logic              p0_rsp_err,
   output logic [DATA_W-1:0] p0_rsp_rdata,
   input  logic              p1_valid,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ready,
   output logic              p1_rsp_valid,
   output logic              p1_rsp_err,
   output logic [DATA_W-1:0] p1_rsp_rdata,
   output logic [ADDR_W-1:0] sel_b,
   output logic [ADDR_W-1:0] sel_c,
   output logic [DATA_W-1:0] data_c,
   input  logic [DATA_W-1:0] data_b,
   output logic              busy
);

   state_t                 state;
   cmd_t                   cmd;
   cmd_t                   win;
   logic [1:0]             grant;
   logic                   accept;
   logic [1:0]             rsp_valid;
   logic [1:0]             rsp_err;
   logic [1:0][DATA_W-1:0] rsp_rdata;

   assign accept = (state == IDLE) && !reset && (grant != 2'b00);

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({p1_valid, p0_valid}),
      .update (accept),
      .grant  (grant)
   );

   always_comb begin
      win = '0;
      if (grant[1]) begin
         win = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, owner: 1'b1};
      end else begin
         win = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, owner: 1'b0};
      end
   end

   assign p0_ready     = accept && grant[0];
   assign p1_ready     = accept && grant[1];
   assign busy         = (state != IDLE);
   assign p0_rsp_valid = rsp_valid[0];
   assign p1_rsp_valid = rsp_valid[1];
   assign p0_rsp_err   = rsp_err[0];
   assign p1_rsp_err   = rsp_err[1];
   assign p0_rsp_rdata = rsp_rdata[0];
   assign p1_rsp_rdata = rsp_rdata[1];

   // Bank selects are loaded on accept so they are stable for the whole EXEC cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd       <= '0;
         sel_b     <= '0;
         sel_c     <= PARK_SEL;
         data_c    <= '0;
         rsp_valid <= 2'b00;
         rsp_err   <= 2'b00;
         rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cmd   <= win;
                  state <= EXEC;
                  if (addr_ok(win.addr) && win.we) begin
                     sel_c  <= win.addr;
                     data_c <= win.wdata;
                  end else if (addr_ok(win.addr)) begin
                     sel_b <= win.addr;
                  end else begin
                     sel_c <= PARK_SEL;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            EXEC: begin
               sel_c                <= PARK_SEL;
               data_c               <= '0;
               rsp_valid[cmd.owner] <= 1'b1;
               rsp_err[cmd.owner]   <= !addr_ok(cmd.addr);
               if (addr_ok(cmd.addr) && !cmd.we) begin
                  rsp_rdata[cmd.owner] <= data_b;
               end else begin
                  rsp_rdata[cmd.owner] <= '0;
               end
               state <= RESP;
            end
            RESP: begin
               rsp_valid <= 2'b00;
               state     <= IDLE;
            end
            default: begin
               sel_c     <= PARK_SEL;
               data_c    <= '0;
               rsp_valid <= 2'b00;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
